// File: rtl/bus_demux_1_to_2_pkg.sv
// Shared definitions for the 1-to-2 request demux: state encoding, error data
// returned on a watchdog timeout, and the default target-1 address window.
package bus_demux_1_to_2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Wide enough for any data width up to 64; the top slices what it needs.
    localparam logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [31:0] DEF_T1_MASK  = 32'hFFFF_0000;
    localparam logic [31:0] DEF_T1_MATCH = 32'h1001_0000;

endpackage

// File: rtl/bus_demux_1_to_2_mux.sv
// Return-path data select between the two targets' load data.
module Multiplexer_2_to_1 #(
    parameter int NBits = 32
) (
    input  logic             sel,
    input  logic [NBits-1:0] in0,
    input  logic [NBits-1:0] in1,
    output logic [NBits-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/bus_demux_1_to_2.sv
// Single-outstanding request router: address-decoded split to data RAM (T0) or
// MMIO (T1), registered response return, and a watchdog against silent targets.
module bus_demux_1_to_2
    import bus_demux_1_to_2_pkg::*;
#(
    parameter int               NBits    = 32,
    parameter logic [NBits-1:0] T1_MASK  = NBits'(DEF_T1_MASK),
    parameter logic [NBits-1:0] T1_MATCH = NBits'(DEF_T1_MATCH),
    parameter int               TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             Req_Valid_i,
    output logic             Req_Ready_o,
    input  logic             Req_Write_i,
    input  logic [NBits-1:0] Req_Addr_i,
    input  logic [NBits-1:0] Req_WData_i,

    output logic             Rsp_Valid_o,
    output logic [NBits-1:0] Rsp_Data_o,
    output logic             Error_o,

    output logic             Tgt_Write_o,
    output logic [NBits-1:0] Tgt_Addr_o,
    output logic [NBits-1:0] Tgt_WData_o,

    output logic             T0_Req_Valid_o,
    output logic             T1_Req_Valid_o,
    input  logic             T0_Req_Ready_i,
    input  logic             T1_Req_Ready_i,
    input  logic             T0_Rsp_Valid_i,
    input  logic             T1_Rsp_Valid_i,
    input  logic [NBits-1:0] T0_Rsp_Data_i,
    input  logic [NBits-1:0] T1_Rsp_Data_i
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t           state_p0, state_nxt;
    logic             sel_p0;
    logic             write_p0;
    logic [NBits-1:0] addr_p0;
    logic [NBits-1:0] wdata_p0;
    logic [WD_W-1:0]  wdog_p0;
    logic             rsp_vld_p1;
    logic [NBits-1:0] rsp_data_p1;
    logic             err_p1;

    logic             sel_rdy, sel_rsp, other_rsp, wd_expired;
    logic             accept, rsp_fire, timeout_fire, stray;
    logic [NBits-1:0] mux_data;

    assign sel_rdy    = sel_p0 ? T1_Req_Ready_i : T0_Req_Ready_i;
    assign sel_rsp    = sel_p0 ? T1_Rsp_Valid_i : T0_Rsp_Valid_i;
    assign other_rsp  = sel_p0 ? T0_Rsp_Valid_i : T1_Rsp_Valid_i;
    assign wd_expired = (wdog_p0 == WD_LAST);

    Multiplexer_2_to_1 #(.NBits(NBits)) u_rsp_mux (
        .sel (sel_p0),
        .in0 (T0_Rsp_Data_i),
        .in1 (T1_Rsp_Data_i),
        .out (mux_data)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= ST_IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            ST_IDLE: if (Req_Valid_i) state_nxt = ST_REQ;
            ST_REQ:  if (sel_rdy)     state_nxt = sel_rsp ? ST_IDLE : ST_RSP;
            ST_RSP:  if (sel_rsp || wd_expired) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Req_Ready_o    = 1'b0;
        T0_Req_Valid_o = 1'b0;
        T1_Req_Valid_o = 1'b0;
        accept         = 1'b0;
        rsp_fire       = 1'b0;
        timeout_fire   = 1'b0;
        stray          = 1'b0;
        case (state_p0)
            ST_IDLE: begin
                Req_Ready_o = 1'b1;
                accept      = Req_Valid_i;
                stray       = T0_Rsp_Valid_i | T1_Rsp_Valid_i;
            end
            ST_REQ: begin
                T0_Req_Valid_o = ~sel_p0;
                T1_Req_Valid_o = sel_p0;
                rsp_fire       = sel_rdy & sel_rsp;
                stray          = other_rsp;
            end
            ST_RSP: begin
                rsp_fire     = sel_rsp | wd_expired;
                timeout_fire = ~sel_rsp & wd_expired;
                stray        = other_rsp;
            end
            default: ;
        endcase
    end

    // Request capture, watchdog and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_p0      <= 1'b0;
            write_p0    <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            wdog_p0     <= '0;
            rsp_vld_p1  <= 1'b0;
            rsp_data_p1 <= '0;
            err_p1      <= 1'b0;
        end else begin
            if (accept) begin
                sel_p0   <= ((Req_Addr_i & T1_MASK) == T1_MATCH);
                write_p0 <= Req_Write_i;
                addr_p0  <= Req_Addr_i;
                wdata_p0 <= Req_WData_i;
            end
            if (state_p0 == ST_RSP) begin
                wdog_p0 <= wdog_p0 + 1'b1;
            end else begin
                wdog_p0 <= '0;
            end
            rsp_vld_p1 <= rsp_fire;
            if (rsp_fire) begin
                rsp_data_p1 <= timeout_fire ? ERR_DATA[NBits-1:0] : mux_data;
            end
            if (stray || timeout_fire) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign Tgt_Write_o = write_p0;
    assign Tgt_Addr_o  = addr_p0;
    assign Tgt_WData_o = wdata_p0;
    assign Rsp_Valid_o = rsp_vld_p1;
    assign Rsp_Data_o  = rsp_data_p1;
    assign Error_o     = err_p1;

endmodule

// File: tb/tb_bus_demux_1_to_2.sv
// Bench for bus_demux_1_to_2: directed vector table, hand-written corner
// sequences and randomized transactions against a per-transaction timing model.
module tb_bus_demux_1_to_2;

    localparam int          NB       = 32;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] T1_MASK  = 32'hFFFF_0000;
    localparam logic [31:0] T1_MATCH = 32'h1001_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Req_Valid_i = 1'b0, Req_Ready_o, Req_Write_i = 1'b0;
    logic [NB-1:0] Req_Addr_i = '0, Req_WData_i = '0;
    logic          Rsp_Valid_o, Error_o, Tgt_Write_o;
    logic [NB-1:0] Rsp_Data_o, Tgt_Addr_o, Tgt_WData_o;
    logic          T0_Req_Valid_o, T1_Req_Valid_o;
    logic          T0_Req_Ready_i = 1'b0, T1_Req_Ready_i = 1'b0;
    logic          T0_Rsp_Valid_i = 1'b0, T1_Rsp_Valid_i = 1'b0;
    logic [NB-1:0] T0_Rsp_Data_i = '0, T1_Rsp_Data_i = '0;

    int errors = 0;
    int checks = 0;
    bit err_exp = 1'b0;

    always #5 clk = ~clk;

    bus_demux_1_to_2 #(
        .NBits(NB), .T1_MASK(T1_MASK), .T1_MATCH(T1_MATCH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .Req_Valid_i(Req_Valid_i), .Req_Ready_o(Req_Ready_o),
        .Req_Write_i(Req_Write_i), .Req_Addr_i(Req_Addr_i), .Req_WData_i(Req_WData_i),
        .Rsp_Valid_o(Rsp_Valid_o), .Rsp_Data_o(Rsp_Data_o), .Error_o(Error_o),
        .Tgt_Write_o(Tgt_Write_o), .Tgt_Addr_o(Tgt_Addr_o), .Tgt_WData_o(Tgt_WData_o),
        .T0_Req_Valid_o(T0_Req_Valid_o), .T1_Req_Valid_o(T1_Req_Valid_o),
        .T0_Req_Ready_i(T0_Req_Ready_i), .T1_Req_Ready_i(T1_Req_Ready_i),
        .T0_Rsp_Valid_i(T0_Rsp_Valid_i), .T1_Rsp_Valid_i(T1_Rsp_Valid_i),
        .T0_Rsp_Data_i(T0_Rsp_Data_i), .T1_Rsp_Data_i(T1_Rsp_Data_i)
    );

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;   // > TIMEOUT: the target never answers
        bit          stray;     // pulse the other target's response once
        bit          exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Req_Valid_i = 1'b0;
        T0_Req_Ready_i = 1'b0; T1_Req_Ready_i = 1'b0;
        T0_Rsp_Valid_i = 1'b0; T1_Rsp_Valid_i = 1'b0;
    endtask

    // Cycle 0 is the accept cycle; the target sees ready at cycle m and its
    // response rsp_dly cycles later; the response pulse is due at cycle e.
    task automatic run_txn(input vec_t v);
        int m, e;
        bit to, s_rdy, s_rsp, o_rsp, tv;
        m  = 1 + v.rdy_dly;
        to = (v.rsp_dly > TIMEOUT);
        e  = to ? m + TIMEOUT + 1 : m + v.rsp_dly + 1;
        for (int c = 0; c <= e; c++) begin
            Req_Valid_i = (c == 0);
            Req_Write_i = (c == 0) ? v.w : 1'($urandom);
            Req_Addr_i  = (c == 0) ? v.addr : $urandom;
            Req_WData_i = (c == 0) ? v.wdata : $urandom;
            s_rdy = (c == m);
            s_rsp = !to && (c == m + v.rsp_dly);
            o_rsp = v.stray && (c == m + 1);
            T0_Req_Ready_i = v.exp_sel ? 1'b0 : s_rdy;
            T1_Req_Ready_i = v.exp_sel ? s_rdy : 1'b0;
            T0_Rsp_Valid_i = v.exp_sel ? o_rsp : s_rsp;
            T1_Rsp_Valid_i = v.exp_sel ? s_rsp : o_rsp;
            T0_Rsp_Data_i  = (!v.exp_sel && s_rsp) ? v.rdata : $urandom;
            T1_Rsp_Data_i  = (v.exp_sel && s_rsp) ? v.rdata : $urandom;
            #1;
            tv = (c >= 1 && c <= m);
            chk("ctl", {Req_Ready_o, Rsp_Valid_o, T0_Req_Valid_o, T1_Req_Valid_o},
                {(c == 0 || c == e), (c == e), (!v.exp_sel && tv), (v.exp_sel && tv)});
            if (tv) chk("tgt_req", {Tgt_Write_o, Tgt_Addr_o, Tgt_WData_o}, {v.w, v.addr, v.wdata});
            if (c == e && !v.w) chk("rsp_data", Rsp_Data_o, v.exp_data);
            step();
        end
        idle_inputs();
        if (to || v.stray) err_exp = 1'b1;
        chk("rsp_one_cycle", {Rsp_Valid_o, Req_Ready_o}, 2'b01);
        chk("error_flag", Error_o, err_exp);
        step();
    endtask

    function automatic vec_t model_vec(input bit w, input logic [31:0] a, wd, rd,
                                       input int rdy, rsp, input bit st);
        vec_t v;
        v.w = w; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.stray = st;
        v.exp_sel  = ((a & T1_MASK) == T1_MATCH);
        v.exp_data = (rsp > TIMEOUT) ? 32'hFFFF_FFFF : rd;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        //           w  addr          wdata         rdata         rdy rsp stray sel exp_data
        tbl[0] = '{1'b0, 32'h0000_0004, 32'h0,        32'h1234_5678, 0, 0,  1'b0, 1'b0, 32'h1234_5678};
        tbl[1] = '{1'b1, 32'h1001_0008, 32'h0000_00A5, 32'h0,        3, 2,  1'b0, 1'b1, 32'h0};
        tbl[2] = '{1'b0, 32'h1001_FFFC, 32'h0,        32'h0BAD_F00D, 0, 16, 1'b0, 1'b1, 32'h0BAD_F00D};
        tbl[3] = '{1'b0, 32'h1002_0000, 32'h0,        32'h5555_AAAA, 1, 1,  1'b0, 1'b0, 32'h5555_AAAA};
        tbl[4] = '{1'b0, 32'h1000_FFFC, 32'h0,        32'h0F0F_0F0F, 2, 4,  1'b0, 1'b0, 32'h0F0F_0F0F};
        tbl[5] = '{1'b0, 32'h1001_0000, 32'h0,        32'h1111_1111, 0, 99, 1'b0, 1'b1, 32'hFFFF_FFFF};
        tbl[6] = '{1'b0, 32'h0000_0100, 32'h0,        32'hCAFE_BABE, 1, 3,  1'b1, 1'b0, 32'hCAFE_BABE};

        repeat (3) step();
        chk("reset_state", {Req_Ready_o, Rsp_Valid_o, Rsp_Data_o, Error_o, Tgt_Write_o,
                            Tgt_Addr_o, Tgt_WData_o, T0_Req_Valid_o, T1_Req_Valid_o},
            {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
        reset = 1'b0;
        step();

        foreach (tbl[i]) run_txn(tbl[i]);

        // Back-to-back loads with Req_Valid_i held high
        Req_Valid_i = 1'b1; Req_Write_i = 1'b0; Req_Addr_i = 32'h10;
        #1; chk("b2b_accept1", Req_Ready_o, 1'b1);
        step();
        Req_Addr_i = 32'h20;
        T0_Req_Ready_i = 1'b1; T0_Rsp_Valid_i = 1'b1; T0_Rsp_Data_i = 32'hD1D1_D1D1;
        #1; chk("b2b_req1", {T0_Req_Valid_o, Tgt_Addr_o}, {1'b1, 32'h10});
        step();
        T0_Req_Ready_i = 1'b0; T0_Rsp_Valid_i = 1'b0;
        #1; chk("b2b_rsp1", {Rsp_Valid_o, Req_Ready_o, Rsp_Data_o}, {1'b1, 1'b1, 32'hD1D1_D1D1});
        step();
        Req_Valid_i = 1'b0;
        T0_Req_Ready_i = 1'b1; T0_Rsp_Valid_i = 1'b1; T0_Rsp_Data_i = 32'hD2D2_D2D2;
        #1; chk("b2b_req2", {T0_Req_Valid_o, Tgt_Addr_o, Rsp_Valid_o}, {1'b1, 32'h20, 1'b0});
        step();
        idle_inputs();
        #1; chk("b2b_rsp2", {Rsp_Valid_o, Rsp_Data_o}, {1'b1, 32'hD2D2_D2D2});
        step();

        // Reset while waiting in RSP, then a T0 response with nothing outstanding
        Req_Valid_i = 1'b1; Req_Addr_i = 32'h1001_0004;
        step();
        Req_Valid_i = 1'b0; T1_Req_Ready_i = 1'b1;
        step();
        T1_Req_Ready_i = 1'b0;
        step();
        #2 reset = 1'b1;
        #1 chk("mid_reset", {Req_Ready_o, Rsp_Valid_o, Rsp_Data_o, Error_o, Tgt_Write_o,
                             Tgt_Addr_o, Tgt_WData_o, T0_Req_Valid_o, T1_Req_Valid_o},
            {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
        err_exp = 1'b0;
        step();
        reset = 1'b0;
        step();
        T0_Rsp_Valid_i = 1'b1; T0_Rsp_Data_i = 32'hDEAD_0000;
        step();
        T0_Rsp_Valid_i = 1'b0;
        #1; chk("idle_stray", {Rsp_Valid_o, Error_o}, 2'b01);
        err_exp = 1'b1;
        step();
        chk("idle_stray_norsp", Rsp_Valid_o, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int rsp;
            a = ($urandom_range(0, 1) == 1) ? (32'h1001_0000 | ($urandom & 32'hFFFC)) : $urandom;
            rsp = ($urandom_range(0, 5) == 0) ? TIMEOUT + 1 + int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 6));
            run_txn(model_vec(1'($urandom), a, $urandom, $urandom,
                              int'($urandom_range(0, 3)), rsp, ($urandom_range(0, 7) == 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_demux_1_to_2.md
# bus_demux_1_to_2

Routes single-initiator memory requests from the core's load/store path to one of two targets (target 0: data RAM; target 1: MMIO/GPIO) by address match, and returns the selected target's response to the initiator. It is the splitting counterpart of the 2-to-1 read-data select on the return path. It holds one outstanding transaction, registers the request toward the target, and has a response watchdog so a silent target cannot hang the core.

## Interface
- NBits, 32, data and address width
- T1_MASK, 32'hFFFF_0000, address bits compared for target 1
- T1_MATCH, 32'h1001_0000, target 1 selected when (Addr & T1_MASK) == T1_MATCH, else target 0
- TIMEOUT, 16, cycles in RSP without a response before a forced error response (1..255)

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- Req_Valid_i / Req_Ready_o  in/out  1  initiator request handshake
- Req_Write_i  input  1  1 = store, 0 = load
- Req_Addr_i, Req_WData_i  input  NBits  request address and store data
- Rsp_Valid_o  output  1  one-cycle response pulse; the initiator always accepts
- Rsp_Data_o  output  NBits  load data; don't-care for stores
- Error_o  output  1  sticky error flag; cleared only by reset
- Tgt_Write_o, Tgt_Addr_o, Tgt_WData_o  output  1/NBits/NBits  registered request, shared by both targets
- T0_Req_Valid_o, T1_Req_Valid_o  output  1  per-target request valid
- T0_Req_Ready_i, T1_Req_Ready_i  input  1  per-target request ready
- T0_Rsp_Valid_i, T1_Rsp_Valid_i  input  1  per-target response strobe; also the ack for stores
- T0_Rsp_Data_i, T1_Rsp_Data_i  input  NBits  per-target load data

## Operation
- States: IDLE, REQ, RSP.
- IDLE
  - Req_Ready_o = 1.
  - On Req_Valid_i: latch write, address, write data and target select (sel); go to REQ.
- REQ
  - T{sel}_Req_Valid_o = 1; the other target's valid stays 0.
  - Request fields are held stable until T{sel}_Req_Ready_i.
  - Ready=1 and T{sel}_Rsp_Valid_i=1 in the same cycle: the response is accepted immediately; go to IDLE.
  - Ready=1 alone: go to RSP; watchdog cleared.
- RSP
  - On T{sel}_Rsp_Valid_i: capture T{sel}_Rsp_Data_i; go to IDLE.
  - Watchdog increments each cycle. On reaching TIMEOUT: respond with data all-ones, set Error_o, go to IDLE.
- Response output
  - Rsp_Valid_o and Rsp_Data_o are registered.
  - Rsp_Valid_o is high exactly one cycle: the first cycle back in IDLE.
- Stray responses
  - Any Rsp_Valid_i from the non-selected target, or from any target in IDLE, is ignored and sets Error_o.
  - This includes a late response after a timeout.

## Timing
- Reset values
  - state IDLE; Req_Ready_o=1.
  - Rsp_Valid_o=0, Rsp_Data_o=0, Error_o=0.
  - Tgt_* = 0, T0/T1_Req_Valid_o = 0; watchdog 0.
- Accept at cycle N → T{sel}_Req_Valid_o high from N+1.
- Target ready at M, response at K > M → Rsp_Valid_o at K+1.
- Best case: ready and response at N+1 → Rsp_Valid_o at N+2.
- Req_Ready_o is high again in the same cycle as Rsp_Valid_o, so back-to-back throughput is one transaction per 2 cycles minimum.
- Timeout: TIMEOUT cycles after entering RSP with no response → Rsp_Valid_o the following cycle.
- Reset mid-transaction: the transaction is dropped and all outputs return to reset values asynchronously. No response is ever issued for the dropped transaction.

## Structure
- Shared package holds:
  - state encoding (IDLE/REQ/RSP)
  - error-data constant (all ones)
  - default T1_MASK/T1_MATCH for the memory map
- Sub-module: Multiplexer_2_to_1 (NBits) selects T0/T1_Rsp_Data_i by registered sel before the output register.
- Watchdog is an inline counter, $clog2(TIMEOUT+1) bits.

## Test plan
- Load 0x0000_0004, T0 ready and rsp at N+1 with data 0x1234_5678 → T0_Req_Valid_o at N+1 only, Rsp_Valid_o at N+2 with 0x1234_5678, T1_Req_Valid_o never high.
- Store 0x1001_0008, data 0xA5, T1 ready delayed 3 cycles → Tgt_* stable through REQ, T1 ack → Rsp_Valid_o one cycle, Error_o=0.
- Load 0x1001_0000, T1 ready but never responds → after TIMEOUT=16 cycles Rsp_Data_o=0xFFFF_FFFF, Error_o=1 and remains 1.
- During an outstanding T0 load, T1_Rsp_Valid_i pulses → ignored (no Rsp_Valid_o), Error_o=1; T0 response still returned correctly.
- Back-to-back loads with Req_Valid_i held high → second accepted in the cycle the first's Rsp_Valid_o is high.
- Assert reset while in RSP → outputs at reset values immediately, Req_Ready_o=1; a subsequent T0 response produces no Rsp_Valid_o and sets Error_o.
